stream_padder: RTL

Streaming, parametrised message padder placed between the byte-stream front end and the block-cipher/hash core. It packs BWIDTH-bit input words into IWIDTH-bit blocks and, on the final word, appends a single `1` marker bit followed by zero fill. It inserts an extra block when the marker does not fit in the current block. Optionally it appends the message bit length. Both sides use valid/ready handshakes, and a single block buffer sits between them.

---
 rtl/stream_padder_if.sv | 29 ++
 rtl/stream_padder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/stream_padder_if.sv
// Valid/ready bundle between the byte-stream front end, stream_padder and the block core.
// master = environment side, slave = padder side.
interface stream_padder_if #(
   parameter int unsigned IWIDTH = 64,
   parameter int unsigned BWIDTH = 32
);
   localparam int unsigned BYW = $clog2(BWIDTH / 8 + 1);

   logic [BWIDTH-1:0] in_data;
   logic              in_valid;
   logic              in_last;
   logic [BYW-1:0]    in_bytes;
   logic              in_ready;
   logic [IWIDTH-1:0] out_block;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              padded;

   modport master (
      output in_data, in_valid, in_last, in_bytes, out_ready,
      input  in_ready, out_block, out_valid, out_last, padded
   );

   modport slave (
      input  in_data, in_valid, in_last, in_bytes, out_ready,
      output in_ready, out_block, out_valid, out_last, padded
   );
endinterface

// File: rtl/stream_padder.sv
// Packs BWIDTH-bit words into IWIDTH-bit blocks and appends 0x80 marker plus zero fill.
// Optional length field enabled by defining PADDER_LENGTH_EN.
module stream_padder #(
   parameter int unsigned IWIDTH = 64,
   parameter int unsigned BWIDTH = 32,
   parameter int unsigned LWIDTH = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   stream_padder_if.slave bus
);
   localparam int unsigned BB    = BWIDTH / 8;
   localparam int unsigned IB    = IWIDTH / 8;
   localparam int unsigned RATIO = IWIDTH / BWIDTH;
`ifdef PADDER_LENGTH_EN
   localparam int unsigned LB    = LWIDTH / 8;
   localparam int unsigned CW    = LWIDTH - 3;
`else
   localparam int unsigned LB    = 0;
`endif
   localparam int unsigned IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned BYW   = $clog2(BB + 1);
   localparam int unsigned PW    = $clog2(IB + 1) + 1;

   localparam logic [PW-1:0] ROOM   = PW'(IB - LB);
   localparam logic [PW-1:0] IB_P   = PW'(IB);

   localparam logic [1:0] S_FILL  = 2'd0;
   localparam logic [1:0] S_EMIT  = 2'd1;
   localparam logic [1:0] S_EXTRA = 2'd2;

   if ((IWIDTH % BWIDTH) != 0 || (BWIDTH % 8) != 0 || (LWIDTH % 8) != 0 || (LWIDTH + 8) > IWIDTH)
   begin : g_cfg_err
      $error("stream_padder: invalid IWIDTH/BWIDTH/LWIDTH combination");
   end

   logic [1:0]        state_q, state_d;
   logic [IDXW-1:0]   word_idx_q, word_idx_d;
   logic [IWIDTH-1:0] block_q, block_d;
   logic              last_q, last_d;
   logic              padded_q, padded_d;
   logic              mark_q, mark_d;
   logic              extra_q, extra_d;
`ifdef PADDER_LENGTH_EN
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     cnt_acc;
`endif

   logic              in_ready_w;
   logic [PW-1:0]     base;
   logic [PW-1:0]     p;
   logic              has_mark;
   logic              fits;
   logic [IWIDTH-1:0] fill_blk;
   logic [IWIDTH-1:0] extra_blk;

   assign in_ready_w    = rst_n && (state_q == S_FILL);
   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = (state_q == S_EMIT);
   assign bus.out_block = block_q;
   assign bus.out_last  = last_q;
   assign bus.padded    = padded_q;

   // p is the byte position just past the last valid data byte of the final word
   assign base     = PW'(word_idx_q) * PW'(BB);
   assign p        = base + PW'(bus.in_bytes);
   assign has_mark = (p < IB_P);
   assign fits     = (p < ROOM);

`ifdef PADDER_LENGTH_EN
   assign cnt_acc = cnt_q + (bus.in_last ? CW'(bus.in_bytes) : CW'(BB));
`endif

   always_comb begin
      fill_blk = block_q;
      for (int unsigned k = 0; k < RATIO; k++) begin
         for (int unsigned j = 0; j < BB; j++) begin
            if (IDXW'(k) == word_idx_q) begin
               if (!bus.in_last || (BYW'(j) < bus.in_bytes))
                  fill_blk[IWIDTH-1-8*(k*BB+j) -: 8] = bus.in_data[BWIDTH-1-8*j -: 8];
               else
                  fill_blk[IWIDTH-1-8*(k*BB+j) -: 8] = '0;
            end else if (bus.in_last && (IDXW'(k) > word_idx_q)) begin
               fill_blk[IWIDTH-1-8*(k*BB+j) -: 8] = '0;
            end
            if (bus.in_last && (PW'(k*BB+j) == p))
               fill_blk[IWIDTH-1-8*(k*BB+j) -: 8] = 8'h80;
         end
      end
`ifdef PADDER_LENGTH_EN
      if (bus.in_last && fits)
         fill_blk[LWIDTH-1:0] = {cnt_acc, 3'b000};
`endif
   end

   always_comb begin
      extra_blk = '0;
      if (!mark_q)
         extra_blk[IWIDTH-1 -: 8] = 8'h80;
`ifdef PADDER_LENGTH_EN
      extra_blk[LWIDTH-1:0] = {cnt_q, 3'b000};
`endif
   end

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      block_d    = block_q;
      last_d     = last_q;
      padded_d   = padded_q;
      mark_d     = mark_q;
      extra_d    = extra_q;
`ifdef PADDER_LENGTH_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         S_FILL: begin
            if (bus.in_valid && in_ready_w) begin
               block_d = fill_blk;
`ifdef PADDER_LENGTH_EN
               cnt_d   = cnt_acc;
`endif
               if (bus.in_last) begin
                  state_d = S_EMIT;
                  if (has_mark)
                     mark_d = 1'b1;
                  if (fits) begin
                     last_d   = 1'b1;
                     padded_d = 1'b1;
                     extra_d  = 1'b0;
                  end else begin
                     last_d   = 1'b0;
                     padded_d = has_mark;
                     extra_d  = 1'b1;
                  end
               end else if (word_idx_q == IDXW'(RATIO - 1)) begin
                  state_d  = S_EMIT;
                  last_d   = 1'b0;
                  padded_d = 1'b0;
                  extra_d  = 1'b0;
               end else begin
                  word_idx_d = word_idx_q + 1'b1;
               end
            end
         end
         S_EMIT: begin
            if (bus.out_ready) begin
               word_idx_d = '0;
               state_d    = extra_q ? S_EXTRA : S_FILL;
               if (last_q) begin
                  mark_d = 1'b0;
`ifdef PADDER_LENGTH_EN
                  cnt_d  = '0;
`endif
               end
            end
         end
         S_EXTRA: begin
            block_d  = extra_blk;
            state_d  = S_EMIT;
            last_d   = 1'b1;
            padded_d = 1'b1;
            extra_d  = 1'b0;
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_FILL;
         word_idx_q <= '0;
         block_q    <= '0;
         last_q     <= 1'b0;
         padded_q   <= 1'b0;
         mark_q     <= 1'b0;
         extra_q    <= 1'b0;
`ifdef PADDER_LENGTH_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         block_q    <= block_d;
         last_q     <= last_d;
         padded_q   <= padded_d;
         mark_q     <= mark_d;
         extra_q    <= extra_d;
`ifdef PADDER_LENGTH_EN
         cnt_q      <= cnt_d;
`endif
      end
   end
endmodule
